// File: rtl/render_cmd_slave.sv
// Avalon-MM slave front-end for the sprite renderer: holds x/y/texture registers and
// turns PLOT writes into commands queued in a first-word-fall-through FIFO.
module render_cmd_slave #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned X_MAX = 319,
    parameter int unsigned Y_MAX = 239
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_x,
    output logic [8:0]  cmd_y,
    output logic [6:0]  cmd_tex,
    input  logic        engine_busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [9:0] XMax = 10'(X_MAX);
    localparam logic [8:0] YMax = 9'(Y_MAX);

    localparam logic [3:0] AddrStatus = 4'd0;
    localparam logic [3:0] AddrX      = 4'd1;
    localparam logic [3:0] AddrY      = 4'd2;
    localparam logic [3:0] AddrTex    = 4'd4;
    localparam logic [3:0] AddrPlot   = 4'd6;
    localparam logic [3:0] AddrClear  = 4'd7;

    logic [9:0]    x_q;
    logic [8:0]    y_q;
    logic [6:0]    tex_q;
    logic [7:0]    plot_cnt_q;
    logic [25:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic        full;
    logic        empty;
    logic        plot_req;
    logic        clear_req;
    logic        push;
    logic        pop;
    logic [9:0]  x_in;
    logic [8:0]  y_in;
    logic [9:0]  x_clamped;
    logic [8:0]  y_clamped;
    logic [2:0]  occ_sat;
    logic [25:0] head;
    logic [31:0] status;
    logic        unused_wdata;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign plot_req  = slave_write && (slave_address == AddrPlot);
    assign clear_req = slave_write && (slave_address == AddrClear);
    // A full FIFO stalls the PLOT even if a pop frees a slot this cycle.
    assign push      = plot_req && !full;
    assign pop       = !empty && cmd_ready;

    assign slave_waitrequest = plot_req && full;

    assign x_in      = slave_writedata[9:0];
    assign y_in      = slave_writedata[8:0];
    assign x_clamped = (x_in > XMax) ? XMax : x_in;
    assign y_clamped = (y_in > YMax) ? YMax : y_in;
    assign unused_wdata = ^slave_writedata[31:10];

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            tex_q      <= '0;
            plot_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (slave_write && slave_address == AddrX)   x_q   <= x_clamped;
            if (slave_write && slave_address == AddrY)   y_q   <= y_clamped;
            if (slave_write && slave_address == AddrTex) tex_q <= slave_writedata[6:0];

            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                plot_cnt_q <= plot_cnt_q + 8'd1;
            end else if (clear_req) begin
                plot_cnt_q <= '0;
            end

            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {x_q, y_q, tex_q};
    end

    assign head      = mem_q[rd_ptr_q];
    assign cmd_valid = !empty;
    assign cmd_x     = empty ? '0 : head[25:16];
    assign cmd_y     = empty ? '0 : head[15:7];
    assign cmd_tex   = empty ? '0 : head[6:0];

    always_comb begin
        occ_sat = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);
    end

    assign status = {16'd0, plot_cnt_q, 3'd0, occ_sat, full, (!empty || engine_busy)};

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                AddrStatus: slave_readdata = status;
                AddrX:      slave_readdata = {22'd0, x_q};
                AddrY:      slave_readdata = {23'd0, y_q};
                AddrTex:    slave_readdata = {25'd0, tex_q};
                default:    slave_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_render_cmd_slave.sv
// Bench for render_cmd_slave: a queue-based reference model updated on each clock edge
// predicts register contents and FIFO contents; a negedge monitor compares every cycle.
module tb_render_cmd_slave;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [6:0]  cmd_tex;
    logic        engine_busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rnd_mode = 1'b0;

    // Reference model state
    logic [25:0] exp_q[$];
    logic [9:0]  x_m;
    logic [8:0]  y_m;
    logic [6:0]  tex_m;
    logic [7:0]  cnt_m;

    render_cmd_slave dut (
        .clk               (clk),
        .rst               (rst),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_waitrequest (slave_waitrequest),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_x             (cmd_x),
        .cmd_y             (cmd_y),
        .cmd_tex           (cmd_tex),
        .engine_busy       (engine_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a, input logic rd);
        int unsigned occ;
        logic [2:0] occ3;
        logic busy;
        logic full;
        occ  = exp_q.size();
        occ3 = (occ > 7) ? 3'd7 : 3'(occ);
        busy = (occ != 0) || engine_busy;
        full = (occ == DEPTH);
        if (!rd) return 32'd0;
        case (a)
            4'd0:    return {16'd0, cnt_m, 3'd0, occ3, full, busy};
            4'd1:    return {22'd0, x_m};
            4'd2:    return {23'd0, y_m};
            4'd4:    return {25'd0, tex_m};
            default: return 32'd0;
        endcase
    endfunction

    // Model: applies the register-map rules to what the bench drove into this edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            x_m = 0; y_m = 0; tex_m = 0; cnt_m = 0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (exp_q.size() != 0) && cmd_ready;
            do_push = slave_write && (slave_address == 4'd6) && (exp_q.size() < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({x_m, y_m, tex_m});
                cnt_m = cnt_m + 8'd1;
            end
            if (slave_write) begin
                case (slave_address)
                    4'd1: x_m = (slave_writedata[9:0] > 10'd319) ? 10'd319 : slave_writedata[9:0];
                    4'd2: y_m = (slave_writedata[8:0] > 9'd239) ? 9'd239 : slave_writedata[8:0];
                    4'd4: tex_m = slave_writedata[6:0];
                    4'd7: cnt_m = 8'd0;
                    default: ;
                endcase
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (chk_en) begin
            chk("waitrequest", {31'd0, slave_waitrequest},
                {31'd0, slave_write && slave_address == 4'd6 && exp_q.size() == DEPTH});
            chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0)
                chk("cmd_head", {6'd0, cmd_x, cmd_y, cmd_tex}, {6'd0, exp_q[0]});
            chk("readdata", slave_readdata, exp_rd(slave_address, slave_read));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            cmd_ready   = 1'($urandom_range(0, 1));
            engine_busy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic rd_too);
        int n;
        n = 0;
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        slave_read      = rd_too;
        forever begin
            @(negedge clk);
            if (!slave_waitrequest) break;
            n++;
            if (n > 64) begin
                chk("write_stall_timeout", 32'd1, 32'd0);
                break;
            end
            tick();
        end
        tick();
        slave_write = 1'b0;
        slave_read  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        slave_address = a;
        slave_read    = 1'b1;
        @(negedge clk);
        chk(name, slave_readdata, exp);
        tick();
        slave_read = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        cmd_ready = 1'b0; engine_busy = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_x", {22'd0, cmd_x}, 32'd0);
        chk("rst_cmd_y", {23'd0, cmd_y}, 32'd0);
        chk("rst_cmd_tex", {25'd0, cmd_tex}, 32'd0);
        rd_chk("rst_status", 4'd0, 32'd0);
        rd_chk("rst_x", 4'd1, 32'd0);
        rd_chk("rst_y", 4'd2, 32'd0);
        rd_chk("rst_tex", 4'd4, 32'd0);

        // Basic plot
        wr(4'd4, 32'h6A, 1'b0);
        wr(4'd1, 32'd159, 1'b0);
        wr(4'd2, 32'd119, 1'b0);
        wr(4'd6, 32'hDEAD_BEEF, 1'b0);
        chk("plot1_x", {22'd0, cmd_x}, 32'd159);
        chk("plot1_y", {23'd0, cmd_y}, 32'd119);
        chk("plot1_tex", {25'd0, cmd_tex}, 32'h6A);
        rd_chk("plot1_status", 4'd0, 32'h105);
        cmd_ready = 1'b1; idle(2); cmd_ready = 1'b0;

        // Clamping
        wr(4'd1, 32'd500, 1'b0);
        wr(4'd2, 32'd300, 1'b0);
        rd_chk("clamp_x", 4'd1, 32'd319);
        rd_chk("clamp_y", 4'd2, 32'd239);
        wr(4'd6, 32'd0, 1'b0);
        chk("clamp_plot_x", {22'd0, cmd_x}, 32'd319);
        chk("clamp_plot_y", {23'd0, cmd_y}, 32'd239);
        cmd_ready = 1'b1; idle(2); cmd_ready = 1'b0;

        // Fill, stall, release one slot, drain in order
        for (int i = 0; i < 4; i++) begin
            wr(4'd1, 32'(i), 1'b0);
            wr(4'd6, 32'd0, 1'b0);
        end
        rd_chk("full_status", 4'd0, 32'h613);
        wr(4'd1, 32'd4, 1'b0);
        fork
            wr(4'd6, 32'd0, 1'b0);
            begin
                idle(3);
                cmd_ready = 1'b1;
                idle(1);
                cmd_ready = 1'b0;
            end
        join
        cmd_ready = 1'b1; idle(6); cmd_ready = 1'b0;

        // Count wrap and clear
        wr(4'd7, 32'd0, 1'b0);
        cmd_ready = 1'b1;
        repeat (256) wr(4'd6, $urandom, 1'b0);
        rd_chk("wrap_status", 4'd0, 32'h5);
        repeat (3) wr(4'd6, $urandom, 1'b0);
        wr(4'd7, 32'd0, 1'b0);
        rd_chk("clear_status", 4'd0, 32'h0);
        cmd_ready = 1'b0;

        // Reset mid-operation
        wr(4'd4, 32'h11, 1'b0);
        repeat (3) wr(4'd6, 32'd0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_valid", {31'd0, cmd_valid}, 32'd0);
        rd_chk("rst2_status", 4'd0, 32'd0);
        rd_chk("rst2_x", 4'd1, 32'd0);
        rd_chk("rst2_y", 4'd2, 32'd0);
        rd_chk("rst2_tex", 4'd4, 32'd0);

        // Randomized traffic
        rnd_mode = 1'b1;
        repeat (400) begin
            int op;
            logic [3:0] a;
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 9) < 3) ? 4'd6 : 4'($urandom_range(0, 15));
            case (op)
                0: idle(1);
                1: wr(a, $urandom, 1'b0);
                2: begin
                    slave_address = a; slave_read = 1'b1;
                    tick();
                    slave_read = 1'b0;
                end
                default: wr(a, $urandom, 1'b1);
            endcase
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
        end
        rnd_mode = 1'b0;
        engine_busy = 1'b0;
        cmd_ready = 1'b1;
        idle(8);
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("drained_valid", {31'd0, cmd_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/render_cmd_slave.md
# render_cmd_slave

Avalon-MM slave front-end for the sprite renderer. It holds the x, y and texture-code registers that a host or test master writes, and turns each write to the plot register into a command. Commands are queued in a small FIFO and presented to the drawing engine over a valid/ready handshake. When the queue is full, the block stalls the master through `slave_waitrequest`.

## Interface
- `DEPTH`, 4: command FIFO depth; a power of two, at least 2.
- `X_MAX`, 319: largest legal x coordinate.
- `Y_MAX`, 239: largest legal y coordinate.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `slave_address`  in  4  word address.
- `slave_read`  in  1  read strobe.
- `slave_readdata`  out  32  read data; combinational, valid whenever `slave_read` is high and `slave_waitrequest` is low.
- `slave_write`  in  1  write strobe.
- `slave_writedata`  in  32  write data.
- `slave_waitrequest`  out  1  stall; master must hold address, data and strobe while it is high.
- `cmd_valid`  out  1  FIFO head is valid.
- `cmd_ready`  in  1  engine accepts the head.
- `cmd_x`  out  10  head x coordinate.
- `cmd_y`  out  9  head y coordinate.
- `cmd_tex`  out  7  head texture code.
- `engine_busy`  in  1  engine is still drawing a previously accepted command.

## Operation
- Register map (word addresses):
  - 0 STATUS, read-only:
    - bit0 = busy (FIFO not empty OR `engine_busy`).
    - bit1 = full.
    - bits[4:2] = FIFO occupancy (saturating field).
    - bits[15:8] = plot count.
    - all other bits 0.
  - 1 X: a write stores min(`slave_writedata[9:0]`, `X_MAX`); a read returns the stored value, zero-extended.
  - 2 Y: a write stores min(`slave_writedata[8:0]`, `Y_MAX`); a read returns the stored value, zero-extended.
  - 4 TEX: a write stores `slave_writedata[6:0]`; a read returns the stored value, zero-extended.
  - 6 PLOT: a write pushes {X, Y, TEX} as currently registered; write data is ignored; a read returns 0.
  - 7 CLEAR: a write zeroes the plot count; a read returns 0.
  - Any other address: reads return 0; writes are ignored and complete immediately.
- `slave_waitrequest` = `slave_write` AND address==6 AND FIFO full. Every other access completes in the cycle it is presented.
- A PLOT push and a CLEAR are both counted only on an accepted cycle (waitrequest low). The plot count is 8 bits and wraps from 255 to 0.
- A write to X, Y or TEX updates the register for all later PLOTs. Entries already in the FIFO keep their values.
- The FIFO is first-word-fall-through: `cmd_x`, `cmd_y` and `cmd_tex` always show the head entry. A pop happens when `cmd_valid` AND `cmd_ready`.
- Push and pop in the same cycle with the FIFO not full: occupancy is unchanged and ordering is preserved.
- FIFO full when a PLOT write arrives: the write stalls, even if a pop happens that same cycle. It is accepted on the next cycle, after the freed slot is visible.
- Pop when empty is impossible, because `cmd_valid` is low.
- Read and write strobes asserted together: the write takes effect. Read data reflects register values from before the write.
- Reset mid-operation:
  - The FIFO is flushed.
  - X, Y, TEX and the plot count return to 0.
  - Any stalled write is dropped, and `slave_waitrequest` drops in the cycle after reset is sampled.

## Timing
- Reset values: `slave_waitrequest`=0, `cmd_valid`=0, `cmd_x`=0, `cmd_y`=0, `cmd_tex`=0, `slave_readdata`=0 (while no read is asserted).
- Register write to readback: the value is visible on a read in the next cycle.
- PLOT accepted at edge N: `cmd_valid` is high after edge N, with the entry on the `cmd_*` outputs (1-cycle latency from an empty FIFO).
- Pop at edge N: the next entry, or `cmd_valid`=0, appears after edge N.
- STATUS occupancy and full reflect the state after the last edge. They are not forwarded from same-cycle push or pop.
- Sustained throughput: one PLOT per cycle while `cmd_ready` is held high.

## Test plan
- Reset, then read addresses 0, 1, 2, 4 -> all return 0, `cmd_valid`=0, `slave_waitrequest`=0.
- Write TEX=0x6A, X=159, Y=119, then PLOT -> one cycle later `cmd_valid`=1, `cmd_x`=159, `cmd_y`=119, `cmd_tex`=0x6A. STATUS bits[15:8]=1.
- Write X=500 and Y=300 -> readback gives X=319, Y=239. A following PLOT emits (319, 239).
- With `cmd_ready`=0, issue 5 PLOTs with X=0..4 -> first 4 accepted. The 5th holds `slave_waitrequest`=1 and STATUS reads full. Raise `cmd_ready` for one cycle -> X=0 is popped, the 5th PLOT is accepted on the following cycle, and the outputs drain in order 1, 2, 3, 4.
- Issue 256 PLOTs with `cmd_ready`=1 -> plot count wraps to 0. Then 3 PLOTs followed by a CLEAR -> count reads 0.
- Fill the FIFO to 3 entries, then assert `rst` for one cycle -> `cmd_valid`=0, STATUS=0, and X, Y, TEX read 0.
